// File: rtl/huffman_decoder.sv
// Purpose : serial canonical-Huffman decoder (8 symbols) feeding a symbol FIFO drained over Avalon-MM.
// Latency : symbol_valid/symbol_out and the FIFO entry appear 1 cycle after the edge taking a codeword's last bit.
// Backpr. : none on the bit input; when the FIFO is full and not popped, the symbol is dropped and overflow is flagged.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   encoded_in, enable_in serial code bit (MSB of codeword first) and its qualifier
//   chipselect, read,     Avalon-MM slave; read pops the FIFO head, write issues
//   write, writedata      control: bit0 flush, bit1 clear overflow
//   readdata              {8'b0, count[7:0], 5'b0, pending, overflow, nonempty, 5'b0, head[2:0]}
//   symbol_out/valid      registered last symbol and its one-cycle strobe

// Generic synchronous FIFO with occupancy count. A pop on a full FIFO frees
// the slot a same-edge push needs, so push_ok accounts for it.
module hd_sym_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clr,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       push_ok
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage carries no reset; empty masks stale contents on the read side.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

module huffman_decoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              encoded_in,
  input  logic              enable_in,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic [2:0]        symbol_out,
  output logic              symbol_valid
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // IDLE when no code bits are held, PARTIAL while a codeword is being built.
  typedef enum logic {
    IDLE    = 1'b0,
    PARTIAL = 1'b1
  } dec_state_e;

  logic [4:0]    code_r;
  logic [2:0]    len_r;
  logic [4:0]    code_nxt;
  logic [2:0]    len_nxt;
  dec_state_e    dec_state;

  logic [4:0]    cand;
  logic [2:0]    cand_len;
  logic          match;
  logic [2:0]    match_sym;

  logic          wr_act;
  logic          flush;
  logic          clr_ovf;
  logic          pop_req;
  logic          bit_take;
  logic          push;

  logic [2:0]    head_sym;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push_ok;
  logic          overflow_r;

  logic          unused_ok;

  assign dec_state = (len_r == 3'd0) ? IDLE : PARTIAL;

  // Host control decode: write wins over read on the same access.
  assign wr_act   = chipselect & write;
  assign flush    = wr_act & writedata[0];
  assign clr_ovf  = wr_act & writedata[1];
  assign pop_req  = chipselect & read & ~write;
  // A flush discards any bit arriving on the same edge.
  assign bit_take = enable_in & ~flush;
  assign push     = bit_take & match;

  // Candidate codeword: held bits with the new bit appended as LSB.
  // Because the code is complete and prefix-free, the held prefix already
  // rules out shorter codes, so only the bits that still distinguish
  // symbols at each length need to be looked at.
  always_comb begin
    cand      = {code_r[3:0], encoded_in};
    cand_len  = len_r + 3'd1;
    match     = 1'b0;
    match_sym = 3'd0;
    case (cand_len)
      3'd2: begin
        // 00 -> 0, 01 -> 1; prefix 1 continues.
        if (!cand[1]) begin
          match     = 1'b1;
          match_sym = {2'b00, cand[0]};
        end
      end
      3'd3: begin
        // 100 -> 2, 101 -> 3, 110 -> 4; 111 continues.
        if (cand[2:0] != 3'b111) begin
          match     = 1'b1;
          match_sym = 3'd2 + {1'b0, cand[1:0]};
        end
      end
      3'd4: begin
        // 1110 -> 5; 1111 continues.
        if (cand[3:0] == 4'b1110) begin
          match     = 1'b1;
          match_sym = 3'd5;
        end
      end
      3'd5: begin
        // 11110 -> 6, 11111 -> 7.
        if (cand[4:1] == 4'b1111) begin
          match     = 1'b1;
          match_sym = 3'd6 + {2'b00, cand[0]};
        end
      end
      default: begin
        match     = 1'b0;
        match_sym = 3'd0;
      end
    endcase
  end

  // Decoder next state.
  always_comb begin
    code_nxt = code_r;
    len_nxt  = len_r;
    if (flush) begin
      code_nxt = 5'd0;
      len_nxt  = 3'd0;
    end else if (bit_take) begin
      if (match) begin
        code_nxt = 5'd0;
        len_nxt  = 3'd0;
      end else begin
        code_nxt = cand;
        len_nxt  = cand_len;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      code_r <= 5'd0;
      len_r  <= 3'd0;
    end else begin
      code_r <= code_nxt;
      len_r  <= len_nxt;
    end
  end

  hd_sym_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (3)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .clr     (flush),
    .push    (push),
    .din     (match_sym),
    .pop     (pop_req),
    .dout    (head_sym),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .push_ok (push_ok)
  );

  // Overflow is sticky. A drop on the same edge as a clear-overflow write
  // still sets it, so the host never misses a lost symbol.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      overflow_r <= 1'b0;
    end else if (push && !push_ok) begin
      overflow_r <= 1'b1;
    end else if (clr_ovf) begin
      overflow_r <= 1'b0;
    end
  end

  // Streaming strobe reports every decoded symbol, including dropped ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      symbol_out   <= 3'd0;
      symbol_valid <= 1'b0;
    end else begin
      symbol_valid <= push;
      if (push) begin
        symbol_out <= match_sym;
      end
    end
  end

  always_comb begin
    readdata           = '0;
    readdata[2:0]      = head_sym;
    readdata[8]        = ~fifo_empty;
    readdata[9]        = overflow_r;
    readdata[10]       = (dec_state == PARTIAL);
    readdata[16 +: CW] = fifo_count;
  end

  // Control bits above bit 1 and the top code bit carry no information.
  assign unused_ok = ^{writedata[DATA_W-1:2], code_r[4], fifo_full};

endmodule

// File: tb/tb_huffman_decoder.sv
module tb_huffman_decoder;

  localparam int DEPTH = 8;
  localparam int DW    = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          encoded_in;
  logic          enable_in;
  logic          chipselect;
  logic          read;
  logic          write;
  logic [DW-1:0] writedata;
  logic [DW-1:0] readdata;
  logic [2:0]    symbol_out;
  logic          symbol_valid;

  always #5 clock = ~clock;

  huffman_decoder #(
    .FIFO_DEPTH (DEPTH),
    .DATA_W     (DW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .encoded_in   (encoded_in),
    .enable_in    (enable_in),
    .chipselect   (chipselect),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .readdata     (readdata),
    .symbol_out   (symbol_out),
    .symbol_valid (symbol_valid)
  );

  // Reference model: code table as (value, length) pairs, pending bits as a
  // queue, the FIFO as a queue of symbols.
  int          code_val [8] = '{0, 1, 4, 5, 6, 14, 30, 31};
  int          code_len [8] = '{2, 2, 3, 3, 3, 4, 5, 5};
  bit          pend_q [$];
  int          m_fifo [$];
  bit          m_ovf;
  bit          m_pulse;
  logic [2:0]  m_sym;

  typedef struct {
    logic        chk_rd;
    logic [31:0] rd;
    logic        vld;
    logic [2:0]  sym;
  } exp_t;

  exp_t sb_q [$];

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [31:0] model_rd();
    logic [31:0] r;
    r = '0;
    if (m_fifo.size() > 0) r[2:0] = 3'(m_fifo[0]);
    r[8]     = (m_fifo.size() > 0);
    r[9]     = m_ovf;
    r[10]    = (pend_q.size() != 0);
    r[23:16] = 8'(m_fifo.size());
    return r;
  endfunction

  task automatic model_reset();
    pend_q.delete();
    m_fifo.delete();
    m_ovf   = 1'b0;
    m_pulse = 1'b0;
    m_sym   = 3'd0;
  endtask

  // Effect of one clock edge with the given inputs.
  task automatic model_step(input bit rst, input bit en, input bit b, input bit cs,
                            input bit rd, input bit wr, input logic [31:0] wd);
    bit wract;
    bit pop;
    bit found;
    int v;
    m_pulse = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      wract = cs && wr;
      pop   = cs && rd && !wr;
      if (wract && wd[0]) begin
        pend_q.delete();
        m_fifo.delete();
        m_ovf = 1'b0;
      end else begin
        if (wract && wd[1]) m_ovf = 1'b0;
        if (pop && m_fifo.size() > 0) void'(m_fifo.pop_front());
        if (en) begin
          pend_q.push_back(b);
          v = 0;
          foreach (pend_q[i]) v = v * 2 + int'(pend_q[i]);
          found = 1'b0;
          for (int s = 0; s < 8; s++) begin
            if (!found && pend_q.size() == code_len[s] && v == code_val[s]) begin
              found   = 1'b1;
              m_pulse = 1'b1;
              m_sym   = 3'(s);
              pend_q.delete();
              if (m_fifo.size() < DEPTH) m_fifo.push_back(s);
              else m_ovf = 1'b1;
            end
          end
        end
      end
    end
  endtask

  // One clock: record what the DUT should show during this cycle, drive the
  // inputs for the coming edge, then advance the model across that edge.
  task automatic cyc(input bit rst, input bit en, input bit b, input bit cs,
                     input bit rd, input bit wr, input logic [31:0] wd);
    exp_t e;
    @(posedge clock);
    #1;
    e.chk_rd = cs;
    e.rd     = model_rd();
    e.vld    = m_pulse;
    e.sym    = m_sym;
    sb_q.push_back(e);
    reset      = rst;
    enable_in  = en;
    encoded_in = b;
    chipselect = cs;
    read       = rd;
    write      = wr;
    writedata  = wd;
    model_step(rst, en, b, cs, rd, wr, wd);
  endtask

  task automatic bit_in(input bit b);
    cyc(1'b0, 1'b1, b, 1'b1, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic host_rd();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
  endtask

  task automatic host_wr(input logic [31:0] wd);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, wd);
  endtask

  task automatic send(input logic [4:0] cw, input int len, input int gap);
    for (int i = len - 1; i >= 0; i--) begin
      bit_in(cw[i]);
      idle(gap);
    end
  endtask

  // Monitor: every cycle compares the DUT against the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      if (e.chk_rd) begin
        n_checks++;
        if (readdata !== e.rd) begin
          n_errors++;
          $display("FAIL readdata t=%0t got %h exp %h", $time, readdata, e.rd);
        end
      end
      n_checks++;
      if (symbol_valid !== e.vld) begin
        n_errors++;
        $display("FAIL symbol_valid t=%0t got %b exp %b", $time, symbol_valid, e.vld);
      end
      n_checks++;
      if (symbol_out !== e.sym) begin
        n_errors++;
        $display("FAIL symbol_out t=%0t got %0d exp %0d", $time, symbol_out, e.sym);
      end
    end
  end

  task automatic rand_phase(input int ncyc, input int rd_div);
    bit rst, en, b, cs, rd, wr;
    logic [31:0] wd;
    for (int i = 0; i < ncyc; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      en  = ($urandom_range(0, 3) != 0);
      b   = 1'($urandom_range(0, 1));
      cs  = ($urandom_range(0, 7) != 0);
      rd  = cs && ($urandom_range(0, rd_div - 1) == 0);
      wr  = cs && ($urandom_range(0, 63) == 0);
      wd  = {$urandom_range(0, 65535), 16'($urandom_range(0, 3))};
      cyc(rst, en, b, cs, rd, wr, wd);
    end
  endtask

  initial begin
    reset      = 1'b1;
    encoded_in = 1'b0;
    enable_in  = 1'b0;
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    writedata  = '0;
    model_reset();
    repeat (2) @(posedge clock);

    // Reset values, then first cycles out of reset.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    idle(2);

    // Back-to-back codewords 00 01 100 11111, then drain.
    send(5'b00, 2, 0);
    send(5'b01, 2, 0);
    send(5'b100, 3, 0);
    send(5'b11111, 5, 0);
    idle(1);
    repeat (5) host_rd();

    // 1110 with idle gaps between bits.
    send(5'b1110, 4, 3);
    idle(1);
    host_rd();
    idle(1);

    // Nine symbol 0 into an 8-deep FIFO: overflow, then drain.
    repeat (9) send(5'b00, 2, 0);
    idle(1);
    repeat (9) host_rd();

    // Clear overflow, fill, then pop on the final bit of 101.
    host_wr(32'h2);
    repeat (8) send(5'b00, 2, 0);
    bit_in(1'b1);
    bit_in(1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    idle(1);
    repeat (9) host_rd();

    // Flush mid-codeword, then realignment.
    send(5'b111, 3, 0);
    host_wr(32'h1);
    send(5'b01, 2, 0);
    idle(1);
    host_rd();

    // Reset mid-codeword with symbols queued.
    send(5'b00, 2, 0);
    send(5'b01, 2, 0);
    send(5'b11, 2, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    idle(1);
    send(5'b00, 2, 0);
    idle(1);
    host_rd();

    // Flush on the same edge as an arriving bit discards that bit.
    send(5'b1, 1, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1);
    send(5'b101, 3, 0);
    idle(1);
    host_rd();

    // Randomized traffic: frequent reads, then sparse reads to hit overflow.
    rand_phase(2000, 3);
    rand_phase(2000, 12);
    idle(3);

    @(negedge clock);
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain got %0d left exp 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
